// File: rtl/poker_types_pkg.sv
// Shared poker types: card encoding, betting-round stage and dealer FSM states.
// Street helpers map the current stage to the next one and its first board slot.
package poker_types;

    typedef logic [5:0] card_t;

    typedef enum logic [2:0] {IDLE, PREFLOP, FLOP, TURN, RIVER} stage_t;

    typedef enum logic [2:0] {
        S_IDLE, S_SHUF, S_WAIT_LO, S_WAIT_HI, S_DRAW, S_GAP, S_HOLD
    } dstate_t;

    localparam int BOARD_CARDS = 5;
    localparam int FLOP_CARDS  = 3;
    localparam int HOLE_CARDS  = 2;
    localparam int CNT_W       = 6;

    function automatic stage_t next_street(input stage_t s);
        case (s)
            PREFLOP: next_street = FLOP;
            FLOP:    next_street = TURN;
            default: next_street = RIVER;
        endcase
    endfunction

    function automatic logic [2:0] street_base(input stage_t s);
        case (s)
            PREFLOP: street_base = 3'd0;
            FLOP:    street_base = 3'd3;
            default: street_base = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/card_dealer_draw_engine.sv
// Pulls 'count' cards from the deck, one draw every two cycles (DRAW then GAP).
// Latency: card strobe on each draw edge, done strobe during the final GAP cycle.
// Backpressure: holds in DRAW with draw_card low while deck_ready is low.
module draw_engine
    import poker_types::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             deck_ready,
    input  card_t            top_card,
    output logic             draw_card,
    output logic             card_valid,
    output card_t            card,
    output logic [CNT_W-1:0] index,
    output logic             done
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    dstate_t          state, state_nxt;
    logic [CNT_W-1:0] idx, cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                idx <= '0;
                cnt <= count;
            end else if (state == S_GAP && !done) begin
                idx <= idx + ONE;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        draw_card  = 1'b0;
        card_valid = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: if (start) state_nxt = S_DRAW;
            S_DRAW: begin
                if (deck_ready) begin
                    draw_card  = 1'b1;
                    card_valid = 1'b1;
                    state_nxt  = S_GAP;
                end
            end
            S_GAP: begin
                // GAP gives the deck a cycle to present the next top card
                if (idx + ONE == cnt) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_DRAW;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign card  = top_card;
    assign index = idx;

endmodule

// File: rtl/card_dealer.sv
// Texas Hold'em dealer: shuffles, deals hole cards round-robin after the button, then burn+board streets.
// Latency: start_shuffle the cycle after new_hand; two cycles per card; deal_done the cycle after the last GAP.
// Backpressure: waits on deck_ready after shuffle and stalls draws while the deck is not ready.
module card_dealer
    import poker_types::*;
#(
    parameter int NUM_PLAYERS = 4,
    parameter int BURN_EN     = 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     new_hand,
    input  logic                                     advance,
    input  logic [$clog2(NUM_PLAYERS)-1:0]           dealer_pos,
    input  logic                                     deck_ready,
    input  card_t                                    top_card,
    output logic                                     start_shuffle,
    output logic                                     draw_card,
    output card_t [NUM_PLAYERS-1:0][HOLE_CARDS-1:0]  hole_cards,
    output logic                                     hole_valid,
    output card_t [BOARD_CARDS-1:0]                  board,
    output logic [BOARD_CARDS-1:0]                   board_valid,
    output stage_t                                   stage,
    output logic                                     busy,
    output logic                                     deal_done
);

    localparam int SW = $clog2(NUM_PLAYERS);
    localparam logic [SW-1:0]    LAST_SEAT  = SW'(NUM_PLAYERS - 1);
    localparam logic [CNT_W-1:0] NP_CNT     = CNT_W'(NUM_PLAYERS);
    localparam logic [CNT_W-1:0] CNT_HOLE   = CNT_W'(HOLE_CARDS * NUM_PLAYERS);
    localparam logic [CNT_W-1:0] CNT_FLOP   = CNT_W'(FLOP_CARDS + BURN_EN);
    localparam logic [CNT_W-1:0] CNT_STREET = CNT_W'(1 + BURN_EN);
    localparam logic [2:0]       BURN_OFS   = 3'(BURN_EN);

    if (NUM_PLAYERS < 2 || NUM_PLAYERS > 10) begin : g_np_range
        $error("card_dealer: NUM_PLAYERS must be in 2..10");
    end
    if (BURN_EN < 0 || BURN_EN > 1) begin : g_burn_range
        $error("card_dealer: BURN_EN must be 0 or 1");
    end
    if (HOLE_CARDS * NUM_PLAYERS + BOARD_CARDS + 3 * BURN_EN > 52) begin : g_budget
        $error("card_dealer: hand needs more than 52 cards");
    end

    dstate_t          state, state_nxt;
    logic [SW-1:0]    seat, first_seat;
    logic             nh_ok, adv_ok;
    logic             eng_start, eng_done, card_valid;
    logic [CNT_W-1:0] eng_count, eng_index;
    card_t            eng_card;
    logic             hole_slot, is_burn;
    logic [2:0]       board_slot;

    draw_engine u_draw (
        .clk        (clk),
        .reset      (reset),
        .start      (eng_start),
        .count      (eng_count),
        .deck_ready (deck_ready),
        .top_card   (top_card),
        .draw_card  (draw_card),
        .card_valid (card_valid),
        .card       (eng_card),
        .index      (eng_index),
        .done       (eng_done)
    );

    // HOLD is the done cycle; it already accepts the next command
    assign busy          = !(state == S_IDLE || state == S_HOLD);
    assign start_shuffle = (state == S_SHUF);
    assign deal_done     = (state == S_HOLD);
    assign nh_ok         = new_hand && !busy;
    assign adv_ok        = advance && !busy && !new_hand && (stage inside {PREFLOP, FLOP, TURN});

    assign first_seat = (dealer_pos >= LAST_SEAT) ? '0 : dealer_pos + SW'(1);
    assign hole_slot  = (eng_index >= NP_CNT);
    assign is_burn    = (BURN_EN != 0) && (eng_index == '0);
    assign board_slot = street_base(stage) + eng_index[2:0] - BURN_OFS;

    always_comb begin
        state_nxt = state;
        eng_start = 1'b0;
        eng_count = CNT_HOLE;
        case (state)
            S_IDLE, S_HOLD: begin
                state_nxt = S_IDLE;
                if (nh_ok) begin
                    state_nxt = S_SHUF;
                end else if (adv_ok) begin
                    state_nxt = S_DRAW;
                    eng_start = 1'b1;
                    eng_count = (stage == PREFLOP) ? CNT_FLOP : CNT_STREET;
                end
            end
            S_SHUF:    state_nxt = S_WAIT_LO;
            S_WAIT_LO: if (!deck_ready) state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (deck_ready) begin
                    state_nxt = S_DRAW;
                    eng_start = 1'b1;
                end
            end
            S_DRAW:    if (eng_done) state_nxt = S_HOLD;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // stage stays IDLE for the whole hole deal, which is how card routing tells hole from board
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            seat        <= '0;
            stage       <= IDLE;
            hole_cards  <= '0;
            hole_valid  <= 1'b0;
            board       <= '0;
            board_valid <= '0;
        end else begin
            state <= state_nxt;
            if (nh_ok) begin
                stage       <= IDLE;
                hole_valid  <= 1'b0;
                board_valid <= '0;
                seat        <= first_seat;
            end
            if (card_valid) begin
                if (stage == IDLE) begin
                    hole_cards[seat][hole_slot] <= eng_card;
                    seat <= (seat == LAST_SEAT) ? '0 : seat + SW'(1);
                end else if (!is_burn) begin
                    board[board_slot]       <= eng_card;
                    board_valid[board_slot] <= 1'b1;
                end
            end
            if (state == S_DRAW && eng_done) begin
                if (stage == IDLE) begin
                    stage      <= PREFLOP;
                    hole_valid <= 1'b1;
                end else begin
                    stage <= next_street(stage);
                end
            end
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer (4 seats, burns on) against a deck stub that returns card k on the k-th draw.
module tb_card_dealer;
    import poker_types::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic new_hand = 1'b0;
    logic advance = 1'b0;
    logic [1:0] dealer_pos = 2'd0;
    logic deck_ready;
    card_t top_card;
    logic start_shuffle, draw_card, hole_valid, busy, deal_done;
    card_t [3:0][1:0] hole_cards;
    card_t [4:0] board;
    logic [4:0] board_valid;
    stage_t stage;

    always #5 clk = ~clk;

    card_dealer #(.NUM_PLAYERS(4), .BURN_EN(1)) dut (
        .clk(clk), .reset(reset), .new_hand(new_hand), .advance(advance),
        .dealer_pos(dealer_pos), .deck_ready(deck_ready), .top_card(top_card),
        .start_shuffle(start_shuffle), .draw_card(draw_card), .hole_cards(hole_cards),
        .hole_valid(hole_valid), .board(board), .board_valid(board_valid),
        .stage(stage), .busy(busy), .deal_done(deal_done)
    );

    // deck stub: ready drops for 3 cycles after a shuffle, then deals 0,1,2,...
    logic rdy_q = 1'b1;
    logic stall = 1'b0;
    logic [5:0] deck_k = 6'd0;
    int drop = 0;
    assign deck_ready = rdy_q & ~stall;
    assign top_card = deck_k;

    always @(posedge clk) begin
        if (start_shuffle) begin
            deck_k <= 6'd0;
            drop   <= 3;
            rdy_q  <= 1'b0;
        end else if (drop > 0) begin
            drop <= drop - 1;
            if (drop == 1) rdy_q <= 1'b1;
        end else if (draw_card && deck_ready) begin
            deck_k <= deck_k + 6'd1;
        end
    end

    int cyc = 0;
    int shuf_cnt = 0, done_cnt = 0, draw_cnt = 0, cad_err = 0, stall_draw = 0;
    int rise_edge = 0, done_cyc = 0;
    logic prev_draw = 1'b0, prev_rdy = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start_shuffle) shuf_cnt++;
        if (deal_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (draw_card) begin
            draw_cnt++;
            if (prev_draw) cad_err++;
            if (stall) stall_draw++;
        end
        // the posedge that first samples deck_ready high
        if (deck_ready && !prev_rdy) rise_edge = cyc + 1;
        prev_draw = draw_card;
        prev_rdy  = deck_ready;
    end

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            tick;
            if (deal_done) ok = 1'b1;
        end
    endtask

    typedef struct packed {
        logic [1:0]       dp;
        logic [7:0][5:0]  cards;   // cards[2*seat+slot]
    } hvec_t;

    typedef struct packed {
        logic [4:0][5:0]  brd;
        logic [4:0]       vld;
        stage_t           stg;
        logic [2:0]       ndraw;
        logic             ignored;
    } bvec_t;

    function automatic hvec_t mk(input logic [1:0] dp, input int c00, c01, c10, c11, c20, c21, c30, c31);
        hvec_t r;
        r.dp = dp;
        r.cards[0] = 6'(c00); r.cards[1] = 6'(c01);
        r.cards[2] = 6'(c10); r.cards[3] = 6'(c11);
        r.cards[4] = 6'(c20); r.cards[5] = 6'(c21);
        r.cards[6] = 6'(c30); r.cards[7] = 6'(c31);
        return r;
    endfunction

    function automatic logic [29:0] masked_board(input logic [4:0] vld);
        logic [4:0][5:0] m;
        m = '0;
        for (int s = 0; s < 5; s++) if (vld[s]) m[s] = board[s];
        return m;
    endfunction

    hvec_t htab[4];
    bvec_t btab[4];
    logic ok;
    int d0, n;

    initial begin
        htab[0] = mk(2'd3, 0, 4, 1, 5, 2, 6, 3, 7);
        htab[1] = mk(2'd1, 2, 6, 3, 7, 0, 4, 1, 5);
        htab[2] = mk(2'd0, 3, 7, 0, 4, 1, 5, 2, 6);
        htab[3] = mk(2'd2, 1, 5, 2, 6, 3, 7, 0, 4);
        btab[0] = '{brd: {6'd0, 6'd0, 6'd11, 6'd10, 6'd9},  vld: 5'b00111, stg: FLOP,  ndraw: 3'd4, ignored: 1'b0};
        btab[1] = '{brd: {6'd0, 6'd13, 6'd11, 6'd10, 6'd9}, vld: 5'b01111, stg: TURN,  ndraw: 3'd2, ignored: 1'b0};
        btab[2] = '{brd: {6'd15, 6'd13, 6'd11, 6'd10, 6'd9}, vld: 5'b11111, stg: RIVER, ndraw: 3'd2, ignored: 1'b0};
        btab[3] = '{brd: {6'd15, 6'd13, 6'd11, 6'd10, 6'd9}, vld: 5'b11111, stg: RIVER, ndraw: 3'd0, ignored: 1'b1};

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", {start_shuffle, draw_card, hole_valid, board_valid, busy, deal_done}, 0);
        chk("reset_stage", stage, IDLE);
        chk("reset_arrays", {hole_cards, board}, 0);
        reset = 1'b0;
        tick;

        // hole deals; each also fires advance+new_hand mid-deal, which must be ignored
        for (int v = 0; v < 4; v++) begin
            shuf_cnt = 0;
            done_cnt = 0;
            dealer_pos = htab[v].dp;
            new_hand = 1'b1;
            tick;
            new_hand = 1'b0;
            dealer_pos = ~htab[v].dp;
            chk("shuffle_pulse", start_shuffle, 1);
            chk("busy_after_new_hand", busy, 1);
            chk("valids_clear", {hole_valid, board_valid}, 0);
            repeat (8) tick;
            advance = 1'b1;
            new_hand = 1'b1;
            tick;
            advance = 1'b0;
            new_hand = 1'b0;
            wait_done(ok);
            chk("hole_done_seen", ok, 1);
            chk("hole_cards", hole_cards, htab[v].cards);
            chk("hole_valid", hole_valid, 1);
            chk("stage_preflop", stage, PREFLOP);
            chk("board_untouched", board_valid, 0);
            tick;
            chk("one_shuffle", shuf_cnt, 1);
            chk("one_done", done_cnt, 1);
            if (v == 0) chk("done_latency", done_cyc - rise_edge, 16);
            if (v == 1) chk("wrap_seat1_slot1", hole_cards[1][1], 7);
        end

        // board streets from the last hole deal
        for (int j = 0; j < 4; j++) begin
            d0 = draw_cnt;
            advance = 1'b1;
            tick;
            advance = 1'b0;
            if (btab[j].ignored) begin
                chk("ignored_adv_busy", busy, 0);
                repeat (4) tick;
            end else begin
                wait_done(ok);
                chk("street_done_seen", ok, 1);
                tick;
            end
            chk("street_draws", draw_cnt - d0, btab[j].ndraw);
            chk("board", masked_board(btab[j].vld), btab[j].brd);
            chk("board_valid", board_valid, btab[j].vld);
            chk("street_stage", stage, btab[j].stg);
        end

        // new_hand and advance together at PREFLOP: new_hand wins
        dealer_pos = 2'd3;
        new_hand = 1'b1;
        tick;
        new_hand = 1'b0;
        wait_done(ok);
        tick;
        new_hand = 1'b1;
        advance = 1'b1;
        tick;
        new_hand = 1'b0;
        advance = 1'b0;
        chk("collide_shuffle", start_shuffle, 1);
        chk("collide_clear", {hole_valid, board_valid}, 0);
        wait_done(ok);
        chk("collide_done_seen", ok, 1);
        tick;
        chk("collide_stage", stage, PREFLOP);
        chk("collide_no_board", board_valid, 0);
        chk("collide_hole", hole_cards, htab[0].cards);

        // deck stall mid-flop: burn 8 and card 9 drawn, then 5 cycles without deck_ready
        advance = 1'b1;
        tick;
        advance = 1'b0;
        n = draw_card ? 1 : 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            tick;
            if (draw_card) n++;
        end
        tick;
        stall_draw = 0;
        stall = 1'b1;
        repeat (5) tick;
        stall = 1'b0;
        wait_done(ok);
        chk("stall_done_seen", ok, 1);
        tick;
        chk("stall_no_draw", stall_draw, 0);
        chk("stall_flop", masked_board(5'b00111), {6'd0, 6'd0, 6'd11, 6'd10, 6'd9});
        chk("stall_deck_pos", deck_k, 12);
        chk("stall_stage", stage, FLOP);

        // asynchronous reset in the middle of a hole deal
        dealer_pos = 2'd0;
        new_hand = 1'b1;
        tick;
        new_hand = 1'b0;
        repeat (10) tick;
        reset = 1'b1;
        #1;
        chk("midreset_ctrl", {start_shuffle, draw_card, hole_valid, board_valid, busy, deal_done}, 0);
        chk("midreset_stage", stage, IDLE);
        chk("midreset_arrays", {hole_cards, board}, 0);
        tick;
        reset = 1'b0;
        tick;

        chk("draw_cadence", cad_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
